vga_timing_monitor: RTL
=======================

# vga_timing_monitor

Synthesizable VGA sink for the game's display path: it receives hSync/vSync and the 12-bit RGB bus produced by the top-level pixel mux and recovers the horizontal and vertical pixel counters from the sync pulses alone. It checks sync timing against 640x480 parameters, tracks lock over consecutive clean frames, and reports recovered active-area coordinates and a per-frame RGB checksum. It sits beside the VGA pins as a loopback checker for bring-up and regression.

## Interface
- H_SYNC, 96, hSync low width in pixel ticks
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, pixel ticks per line
- V_SYNC, 2, vSync low width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, active lines
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to assert locked
- sys_clk  in  1  100 MHz system clock
- Reset  in  1  asynchronous, active-high reset
- pix_en  in  1  one-cycle pixel-tick strobe; all sampling happens only on pix_en cycles
- hSync, vSync  in  1 each  active-low syncs
- rgb  in  12  {R,G,B} 4 bits each
- rec_hc, rec_vc  out  10 each  recovered counters
- active  out  1  recovered position is inside the active area
- pix_x, pix_y  out  10 each  active-area coordinate (rec_hc-H_SYNC-H_BP, rec_vc-V_SYNC-V_BP); 0 when active=0
- locked  out  1  timing locked
- frame_done  out  1  one-sys_clk pulse at each frame boundary while in TRACK or LOCKED
- frame_crc  out  16  checksum of the last completed frame
- err_count  out  8  saturating timing-error counter

## Operation
- Reset is asynchronous, active-high; clock is sys_clk. Every output resets to 0; state resets to SEARCH.
- On each pix_en cycle: hs_q<=hSync. An hSync fall (hs_q=1, hSync=0) sets hcnt to 0; otherwise hcnt increments, saturating at 1023.
- An hSync rise must occur on the tick where hcnt becomes H_SYNC; any other rise is an error. On an hSync fall, the previous hcnt must equal H_TOTAL-1, otherwise error.
- vSync is sampled only on hSync-fall ticks into vs_q. On such a tick: vs_q=1 and vSync=0 is a frame boundary, vcnt<=0, and the previous vcnt must equal V_TOTAL-1; otherwise vcnt increments, saturating at 1023. vSync must return high on the line where vcnt becomes V_SYNC.
- hcnt saturation (no hSync) is an error.
- States:
  - SEARCH: ignores errors; the first frame boundary moves to TRACK with good=0.
  - TRACK: at each frame boundary, a frame with no errors increments good; good reaching LOCK_FRAMES moves to LOCKED.
  - LOCKED: locked=1.
  - Any error in TRACK or LOCKED returns to SEARCH, clears locked and good, and increments err_count (saturates at 255).
- The errors tracked during a frame are cleared at each frame boundary.
- rec_hc/rec_vc = hcnt/vcnt; active = hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- An hSync fall and a frame boundary on the same tick are both processed in that tick: the line check comes first, then the frame check.

## Timing
- Outputs are registered. Counters, active, pix_x, pix_y and the state update in the same sys_clk edge as the sampling pix_en; they are visible one cycle after the strobe.
- frame_done and the frame_crc update occur on the boundary tick; locked changes on that same edge.
- Without pix_en, all state holds.
- Asserting Reset mid-frame returns the block to SEARCH immediately; err_count is cleared.

## Configuration
- VGA_MON_CRC_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) runs over rgb, MSB first, 12 bits per active pixel tick.
  - frame_crc latches the running value at each frame boundary; the running value then reinitialises.
- VGA_MON_CRC_EN undefined: no CRC logic; frame_crc is held at 0.

## Test plan
- Ideal 800x525 stream, pix_en every 4th cycle -> locked=1 on the 3rd frame boundary; err_count=0; frame_done pulses once per frame.
- Same stream at hcnt=144, vcnt=35 -> active=1, pix_x=0, pix_y=0; at hcnt=783, vcnt=514 -> pix_x=639, pix_y=479; at hcnt=784 -> active=0.
- While locked, inject one 801-tick line -> at the next hSync fall locked=0, err_count=1, SEARCH; re-lock after 3 clean boundaries.
- hSync held high for 1100 ticks while tracking -> saturation error; err_count increments once; rec_hc=1023.
- With VGA_MON_CRC_EN and rgb constant 0x69C -> frame_crc is identical on consecutive frames and matches the model CRC of 307200 words of 0x69C; frame_crc=0 with the macro undefined.
- Reset asserted mid-frame while locked -> locked, err_count, rec_hc, rec_vc and frame_crc all 0 in the same cycle; normal re-lock after release.

Source files
------------

// File: rtl/vga_timing_monitor_if.sv
// VGA loopback bundle: pixel strobe, syncs and RGB toward the monitor; recovered timing, lock and checksum back.
interface vga_timing_monitor_if;
  logic        pix_en;
  logic        hSync;
  logic        vSync;
  logic [11:0] rgb;
  logic [9:0]  rec_hc;
  logic [9:0]  rec_vc;
  logic        active;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic        locked;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic [7:0]  err_count;

  modport master (
    output pix_en, hSync, vSync, rgb,
    input  rec_hc, rec_vc, active, pix_x, pix_y, locked, frame_done, frame_crc, err_count
  );

  modport slave (
    input  pix_en, hSync, vSync, rgb,
    output rec_hc, rec_vc, active, pix_x, pix_y, locked, frame_done, frame_crc, err_count
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Recovers VGA h/v counters from the syncs, checks timing and tracks lock; frame CRC only with VGA_MON_CRC_EN.
// Outputs registered, visible one sys_clk after the pix_en strobe; no backpressure, every pix_en tick is sampled.
module vga_timing_monitor #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 sys_clk,
  input  logic                 Reset,
  vga_timing_monitor_if.slave  vif
);
  localparam logic [9:0] CNT_MAX = 10'h3FF;
  localparam logic [9:0] HS_END  = 10'(H_SYNC);
  localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] HA_LO   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA_HI   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VS_END  = 10'(V_SYNC);
  localparam logic [9:0] VT_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] VA_LO   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA_HI   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t     state, state_nxt;
  logic       hs_q, vs_q, vs_nxt;
  logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
  logic [9:0] pix_x_q, pix_y_q;
  logic       active_q, active_nxt, locked_q, frame_done_q, frame_done_nxt;
  logic [7:0] good, good_nxt, err_cnt, err_cnt_nxt;
  logic       h_fall, h_rise, frame_bnd, tim_err;

  always_comb begin
    h_fall         = hs_q & ~vif.hSync;
    h_rise         = ~hs_q & vif.hSync;
    hcnt_nxt       = (hcnt == CNT_MAX) ? hcnt : hcnt + 10'd1;
    vcnt_nxt       = vcnt;
    vs_nxt         = vs_q;
    frame_bnd      = 1'b0;
    tim_err        = 1'b0;
    state_nxt      = state;
    good_nxt       = good;
    err_cnt_nxt    = err_cnt;
    frame_done_nxt = 1'b0;

    // Line check first, then the frame check on the same tick.
    if (h_fall) begin
      hcnt_nxt = '0;
      if (hcnt != HT_LAST) tim_err = 1'b1;
    end else if (hcnt == CNT_MAX - 10'd1) begin
      tim_err = 1'b1;
    end
    if (h_rise && hcnt_nxt != HS_END) tim_err = 1'b1;

    if (h_fall) begin
      vs_nxt    = vif.vSync;
      frame_bnd = vs_q & ~vif.vSync;
      if (frame_bnd) begin
        vcnt_nxt = '0;
        if (vcnt != VT_LAST) tim_err = 1'b1;
      end else begin
        vcnt_nxt = (vcnt == CNT_MAX) ? vcnt : vcnt + 10'd1;
        if (~vs_q && vif.vSync && vcnt_nxt != VS_END) tim_err = 1'b1;
      end
    end

    active_nxt = (hcnt_nxt >= HA_LO) && (hcnt_nxt < HA_HI) &&
                 (vcnt_nxt >= VA_LO) && (vcnt_nxt < VA_HI);
    frame_done_nxt = frame_bnd && (state != SEARCH);

    if (tim_err && state != SEARCH) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
      if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
    end else if (frame_bnd) begin
      case (state)
        SEARCH: begin
          state_nxt = TRACK;
          good_nxt  = '0;
        end
        TRACK: begin
          good_nxt = good + 8'd1;
          if (good + 8'd1 >= LOCK_N) state_nxt = LOCKED;
        end
        LOCKED:  state_nxt = LOCKED;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      state        <= SEARCH;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      hcnt         <= '0;
      vcnt         <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      active_q     <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      good         <= '0;
      err_cnt      <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (vif.pix_en) begin
        state        <= state_nxt;
        hs_q         <= vif.hSync;
        vs_q         <= vs_nxt;
        hcnt         <= hcnt_nxt;
        vcnt         <= vcnt_nxt;
        active_q     <= active_nxt;
        pix_x_q      <= active_nxt ? hcnt_nxt - HA_LO : 10'd0;
        pix_y_q      <= active_nxt ? vcnt_nxt - VA_LO : 10'd0;
        locked_q     <= (state_nxt == LOCKED);
        frame_done_q <= frame_done_nxt;
        good         <= good_nxt;
        err_cnt      <= err_cnt_nxt;
      end
    end
  end

`ifdef VGA_MON_CRC_EN
  logic [15:0] crc_run, crc_run_nxt, frame_crc_q, frame_crc_nxt;

  // CRC-16-CCITT, 12 RGB bits per pixel, MSB first.
  function automatic logic [15:0] crc12(input logic [15:0] c_in, input logic [11:0] d);
    logic [15:0] c;
    c = c_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    crc_run_nxt   = crc_run;
    frame_crc_nxt = frame_crc_q;
    if (frame_bnd) begin
      frame_crc_nxt = crc_run;
      crc_run_nxt   = 16'hFFFF;
    end else if (active_nxt) begin
      crc_run_nxt = crc12(crc_run, vif.rgb);
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      crc_run     <= 16'hFFFF;
      frame_crc_q <= '0;
    end else if (vif.pix_en) begin
      crc_run     <= crc_run_nxt;
      frame_crc_q <= frame_crc_nxt;
    end
  end

  assign vif.frame_crc = frame_crc_q;
`else
  assign vif.frame_crc = 16'h0000;
`endif

  assign vif.rec_hc     = hcnt;
  assign vif.rec_vc     = vcnt;
  assign vif.active     = active_q;
  assign vif.pix_x      = pix_x_q;
  assign vif.pix_y      = pix_y_q;
  assign vif.locked     = locked_q;
  assign vif.frame_done = frame_done_q;
  assign vif.err_count  = err_cnt;
endmodule
